// File: rtl/mips_muldiv_unit_pkg.sv
// Shared types for the HI/LO multiply/divide unit: select encoding, FSM states
// and the iteration-counter width.
package mips_muldiv_unit_pkg;

   typedef enum logic [1:0] {
      HL_HOLD = 2'b00,
      HL_MOVE = 2'b01,
      HL_DIV  = 2'b10,
      HL_MUL  = 2'b11
   } hl_sel_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_RUN  = 2'b01,
      MD_FIX  = 2'b10
   } muldiv_state_t;

   localparam int XLEN_DEFAULT = 32;

   function automatic int md_cnt_width(input int xlen);
      return $clog2(xlen) + 1;
   endfunction

   localparam int MD_CNT_WIDTH = md_cnt_width(XLEN_DEFAULT);

endpackage

// File: rtl/mips_muldiv_core.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per
// cycle for XLEN cycles. done is high during the cycle of the final step.
module mips_muldiv_core
   import mips_muldiv_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              div_mode,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   output logic              done,
   output logic [2*XLEN-1:0] acc
);

   localparam int CNT_W = md_cnt_width(XLEN);

   logic             running;
   logic [CNT_W-1:0] cnt;
   logic             div_mode_q;
   logic [XLEN-1:0]  operand;

   logic [XLEN:0]      mul_sum;
   logic [2*XLEN-1:0]  mul_next;
   logic [XLEN:0]      div_trial;
   logic [XLEN:0]      div_diff;
   logic               div_ok;
   logic [2*XLEN-1:0]  div_next;

   // Multiply: acc = {partial product, remaining multiplier bits}.
   // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
      mul_next  = {mul_sum, acc[XLEN-1:1]};
      div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      div_diff  = div_trial - {1'b0, operand};
      div_ok    = ~div_diff[XLEN];
      div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]),
                   acc[XLEN-2:0], div_ok};
   end

   assign done = running && (cnt == CNT_W'(XLEN - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         running <= 1'b0;
         cnt     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= '0;
      end else if (running) begin
         cnt <= cnt + 1'b1;
         if (done) running <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         div_mode_q <= div_mode;
         operand    <= div_mode ? op_b : op_a;
         acc        <= div_mode ? {{XLEN{1'b0}}, op_a} : {{XLEN{1'b0}}, op_b};
      end else if (running) begin
         acc <= div_mode_q ? div_next : mul_next;
      end
   end

endmodule

// File: rtl/mips_muldiv_unit.sv
// HI/LO owner: decodes MULT/DIV/MTHI/MTLO commands, drives the iterative core,
// applies sign fixup and raises busy / div_by_zero / cmd_drop status.
module mips_muldiv_unit
   import mips_muldiv_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hi_write,
   input  logic            lo_write,
   input  logic [1:0]      hi_select,
   input  logic [1:0]      lo_select,
   input  logic            unsigned_mult,
   input  logic            unsigned_div,
   input  logic [XLEN-1:0] rs_data,
   input  logic [XLEN-1:0] rt_data,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            busy,
   output logic            div_by_zero,
   output logic            cmd_drop
);

   function automatic logic [XLEN-1:0] neg_if(input logic en, input logic [XLEN-1:0] v);
      return en ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_if_wide(input logic en,
                                                     input logic [2*XLEN-1:0] v);
      return en ? (~v + 1'b1) : v;
   endfunction

   muldiv_state_t state, next_state;
   hl_sel_t       hsel, lsel;

   logic            start_mul, start_div, start;
   logic            sign_uns, rs_neg, rt_neg;
   logic [XLEN-1:0] rs_abs, rt_abs;
   logic            core_done;
   logic [2*XLEN-1:0] core_acc;

   logic            op_div, neg_res, neg_rem, div_zero;
   logic [XLEN-1:0] rs_hold;

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix;

   assign hsel      = hl_sel_t'(hi_select);
   assign lsel      = hl_sel_t'(lo_select);
   assign start_mul = hi_write && lo_write && (hsel == HL_MUL) && (lsel == HL_MUL);
   assign start_div = hi_write && lo_write && (hsel == HL_DIV) && (lsel == HL_DIV);
   assign start     = (state == MD_IDLE) && (start_mul || start_div);

   // Mult and div each honour only their own signedness flag.
   assign sign_uns = start_div ? unsigned_div : unsigned_mult;
   assign rs_neg   = !sign_uns && rs_data[XLEN-1];
   assign rt_neg   = !sign_uns && rt_data[XLEN-1];
   assign rs_abs   = neg_if(rs_neg, rs_data);
   assign rt_abs   = neg_if(rt_neg, rt_data);

   mips_muldiv_core #(.XLEN(XLEN)) u_core (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .div_mode (start_div),
      .op_a     (rs_abs),
      .op_b     (rt_abs),
      .done     (core_done),
      .acc      (core_acc)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= MD_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         MD_IDLE: if (start) next_state = MD_RUN;
         MD_RUN:  if (core_done) next_state = MD_FIX;
         MD_FIX:  next_state = MD_IDLE;
         default: next_state = MD_IDLE;
      endcase
   end

   // Operand side-information captured at the start edge.
   always_ff @(posedge clk) begin
      if (start) begin
         op_div   <= start_div;
         neg_res  <= rs_neg ^ rt_neg;
         neg_rem  <= rs_neg;
         div_zero <= (rt_data == '0);
         rs_hold  <= rs_data;
      end
   end

   always_comb begin
      prod_fix = neg_if_wide(neg_res, core_acc);
      quot_fix = neg_if(neg_res, core_acc[XLEN-1:0]);
      rem_fix  = neg_if(neg_rem, core_acc[2*XLEN-1:XLEN]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi          <= '0;
         lo          <= '0;
         busy        <= 1'b0;
         div_by_zero <= 1'b0;
         cmd_drop    <= 1'b0;
      end else begin
         busy        <= (next_state != MD_IDLE);
         cmd_drop    <= busy && (hi_write || lo_write);
         div_by_zero <= (state == MD_RUN) && core_done && op_div && div_zero;
         if (state == MD_IDLE) begin
            if (hi_write && (hsel == HL_MOVE)) hi <= rs_data;
            if (lo_write && (lsel == HL_MOVE)) lo <= rs_data;
         end else if (state == MD_FIX) begin
            if (op_div) begin
               if (div_zero) begin
                  lo <= '1;
                  hi <= rs_hold;
               end else begin
                  lo <= quot_fix;
                  hi <= rem_fix;
               end
            end else begin
               {hi, lo} <= prod_fix;
            end
         end
      end
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed cases plus randomized
// mult/div traffic compared against an arithmetic reference model.
module tb_mips_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        hi_write = 1'b0, lo_write = 1'b0;
   logic [1:0]  hi_select = 2'b00, lo_select = 2'b00;
   logic        unsigned_mult = 1'b0, unsigned_div = 1'b0;
   logic [31:0] rs_data = '0, rt_data = '0;
   logic [31:0] hi, lo;
   logic        busy, div_by_zero, cmd_drop;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_muldiv_unit #(.XLEN(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .hi_write      (hi_write),
      .lo_write      (lo_write),
      .hi_select     (hi_select),
      .lo_select     (lo_select),
      .unsigned_mult (unsigned_mult),
      .unsigned_div  (unsigned_div),
      .rs_data       (rs_data),
      .rt_data       (rt_data),
      .hi            (hi),
      .lo            (lo),
      .busy          (busy),
      .div_by_zero   (div_by_zero),
      .cmd_drop      (cmd_drop)
   );

   task automatic model(input bit is_div, input bit uns, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] mh,
                        output logic [31:0] ml, output int mdz);
      longint sa, sb, q, r;
      logic [63:0] p;
      mdz = 0;
      if (!is_div) begin
         if (uns) p = {32'b0, a} * {32'b0, b};
         else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
         end
         mh = p[63:32];
         ml = p[31:0];
      end else if (b == 32'h0) begin
         mdz = 1;
         ml  = 32'hFFFF_FFFF;
         mh  = a;
      end else begin
         if (uns) begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
         end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
         end
         q  = sa / sb;
         r  = sa % sb;
         ml = 32'(q);
         mh = 32'(r);
      end
   endtask

   // Caller is at a negedge; command is sampled on the following posedge.
   task automatic issue(input logic hw, input logic lw, input logic [1:0] hs,
                        input logic [1:0] ls, input logic um, input logic ud,
                        input logic [31:0] a, input logic [31:0] b);
      hi_write = hw; lo_write = lw; hi_select = hs; lo_select = ls;
      unsigned_mult = um; unsigned_div = ud; rs_data = a; rt_data = b;
      @(negedge clk);
      hi_write = 1'b0; lo_write = 1'b0; hi_select = 2'b00; lo_select = 2'b00;
      rs_data = $urandom; rt_data = $urandom;
   endtask

   task automatic wait_done(output int bcnt, output int dzc);
      bcnt = 0;
      dzc  = 0;
      while (busy === 1'b1 && bcnt < 200) begin
         bcnt++;
         if (div_by_zero === 1'b1) dzc++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input bit is_div, input bit uns, input logic [31:0] a,
                         input logic [31:0] b, output int bcnt, output int dzc);
      logic um, ud;
      um = is_div ? 1'($urandom) : uns;
      ud = is_div ? uns : 1'($urandom);
      issue(1'b1, 1'b1, is_div ? 2'b10 : 2'b11, is_div ? 2'b10 : 2'b11, um, ud, a, b);
      wait_done(bcnt, dzc);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want %h", hi, 32'h0); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want %h", lo, 32'h0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", div_by_zero); end
      checks++; if (cmd_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got %b want 0", cmd_drop); end
   endtask

   task automatic test_directed();
      int bc, dz;
      run_op(1'b0, 1'b0, 32'd7, 32'd6, bc, dz);
      checks++; if (bc !== 33) begin errors++; $display("FAIL mult7x6_busy got %0d want 33", bc); end
      checks++; if (lo !== 32'h0000_002A) begin errors++; $display("FAIL mult7x6_lo got %h want %h", lo, 32'h2A); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mult7x6_hi got %h want %h", hi, 32'h0); end
      run_op(1'b0, 1'b0, 32'hFFFF_FFFD, 32'd5, bc, dz);
      checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL mult_neg3x5 got %h want %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1); end
      run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dz);
      checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu_max got %h want %h", {hi, lo}, 64'hFFFF_FFFE_0000_0001); end
      run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, bc, dz);
      checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg7_lo got %h want %h", lo, 32'hFFFF_FFFD); end
      checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg7_hi got %h want %h", hi, 32'hFFFF_FFFF); end
      run_op(1'b1, 1'b1, 32'd100, 32'd0, bc, dz);
      checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_lo got %h want %h", lo, 32'hFFFF_FFFF); end
      checks++; if (hi !== 32'h64) begin errors++; $display("FAIL divu_zero_hi got %h want %h", hi, 32'h64); end
      checks++; if (dz !== 1) begin errors++; $display("FAIL divu_zero_flag_cycles got %0d want 1", dz); end
      checks++; if (bc !== 33) begin errors++; $display("FAIL divu_zero_busy got %0d want 33", bc); end
      run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, bc, dz);
      checks++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_ovf got %h want %h", {hi, lo}, 64'h8000_0000); end
      checks++; if (dz !== 0) begin errors++; $display("FAIL div_ovf_flag got %0d want 0", dz); end
   endtask

   task automatic test_move();
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      issue(1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, a, 32'h0);
      checks++; if (hi !== a) begin errors++; $display("FAIL mthi got %h want %h", hi, a); end
      issue(1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, b, 32'h0);
      checks++; if ({hi, lo} !== {a, b}) begin errors++; $display("FAIL mtlo got %h want %h", {hi, lo}, {a, b}); end
      issue(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, ~a, 32'h5);
      issue(1'b1, 1'b0, 2'b11, 2'b11, 1'b0, 1'b0, ~a, 32'h5);
      issue(1'b1, 1'b1, 2'b11, 2'b10, 1'b0, 1'b0, ~a, 32'h5);
      checks++; if ({hi, lo} !== {a, b}) begin errors++; $display("FAIL noop_cmds got %h want %h", {hi, lo}, {a, b}); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noop_busy got %b want 0", busy); end
   endtask

   task automatic test_drop_during_mult();
      logic [31:0] a, b, mh, ml, prev_hi;
      int mdz, bc, dz;
      a = $urandom; b = $urandom;
      model(1'b0, 1'b0, a, b, mh, ml, mdz);
      prev_hi = hi;
      issue(1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 1'b0, a, b);
      repeat (3) @(negedge clk);
      issue(1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 32'h1234, 32'h0);
      checks++; if (cmd_drop !== 1'b1) begin errors++; $display("FAIL mthi_busy_drop got %b want 1", cmd_drop); end
      checks++; if (hi !== prev_hi) begin errors++; $display("FAIL mthi_busy_hi got %h want %h", hi, prev_hi); end
      wait_done(bc, dz);
      checks++; if ({hi, lo} !== {mh, ml}) begin errors++; $display("FAIL mult_after_drop got %h want %h", {hi, lo}, {mh, ml}); end
      checks++; if (cmd_drop !== 1'b0) begin errors++; $display("FAIL drop_clear got %b want 0", cmd_drop); end
   endtask

   task automatic test_reset_mid_div();
      issue(1'b1, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 32'd1000, 32'd7);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_mid_div_hilo got %h want 0", {hi, lo}); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_div_busy got %b want 0", busy); end
      issue(1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 32'hABCD, 32'h0);
      checks++; if (lo !== 32'hABCD) begin errors++; $display("FAIL mtlo_after_rst got %h want %h", lo, 32'hABCD); end
      repeat (40) @(negedge clk);
      checks++; if ({hi, lo} !== {32'h0, 32'hABCD}) begin errors++; $display("FAIL abandoned_op got %h want %h", {hi, lo}, {32'h0, 32'hABCD}); end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random_back_to_back();
      logic [31:0] a, b, mh, ml;
      int mdz, bc, dz;
      bit is_div, uns;
      for (int i = 0; i < 60; i++) begin
         is_div = 1'($urandom);
         uns    = 1'($urandom);
         a = pick_operand();
         b = pick_operand();
         model(is_div, uns, a, b, mh, ml, mdz);
         run_op(is_div, uns, a, b, bc, dz);
         checks++;
         if ({hi, lo} !== {mh, ml} || dz !== mdz || bc !== 33) begin
            errors++;
            $display("FAIL rand%0d div=%0d uns=%0d a=%h b=%h got hi=%h lo=%h dz=%0d busy=%0d want hi=%h lo=%h dz=%0d busy=33",
                     i, is_div, uns, a, b, hi, lo, dz, bc, mh, ml, mdz);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_move();
      test_drop_during_mult();
      test_reset_mid_div();
      test_random_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
